elink_trig_unroller_multi: RTL

Parametrised, multi-channel successor to the single-link trigger unroller. Each channel takes a byte-wide trigger e-link stream and aligns to a fixed-period frame header with a hunt/verify/lock state machine. It then unrolls the payload bits MSB-first into OUT_W-bit trigger words with a per-word valid strobe. The block sits between the e-link deserialisers and the trigger-primitive processing.

---
 rtl/elink_trig_pkg.sv | 17 +
 rtl/elink_trig_unroller_ch.sv | 171 +++++++++++++++++
 rtl/elink_trig_unroller_multi.sv | 54 +++++
 3 files changed

// File: rtl/elink_trig_pkg.sv
// Shared types and helpers for the multi-channel e-link trigger unroller.
package elink_trig_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } trig_state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAF;

    // Whole output words carried by one frame's payload.
    function automatic int words_per_frame(input int din_w, input int out_w, input int frame_bytes);
        return ((frame_bytes - 1) * din_w) / out_w;
    endfunction

endpackage

// File: rtl/elink_trig_unroller_ch.sv
// One e-link channel: header alignment FSM plus MSB-first payload unroller.
module elink_trig_unroller_ch
    import elink_trig_pkg::*;
#(
    parameter int               DIN_W        = 8,
    parameter int               OUT_W        = 10,
    parameter int               FRAME_BYTES  = 6,
    parameter logic [DIN_W-1:0] HEADER       = DIN_W'(HEADER_DEFAULT),
    parameter int               LOCK_COUNT   = 2,
    parameter int               UNLOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] data_in,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    output logic             locked,
    output logic             hdr_err
);

    localparam int PW    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int GW    = $clog2(LOCK_COUNT + 1);
    localparam int MW    = $clog2(UNLOCK_COUNT + 1);
    localparam int CMB_W = OUT_W + DIN_W;
    localparam int CW    = $clog2(CMB_W + 1);
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME_BYTES - 1);

    trig_state_e      state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [GW-1:0]    good_q, good_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic             unroll_q, unroll_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             locked_q, locked_d;
    logic             hdr_err_q, hdr_err_d;

    logic             is_hdr;
    logic [PW-1:0]    pos_next;
    logic [GW-1:0]    good_inc;
    logic [MW-1:0]    miss_inc;
    logic [CMB_W-1:0] comb_bits;
    logic [CMB_W-1:0] rem_mask;
    logic [CW-1:0]    n_bits;
    logic [CW-1:0]    shift_amt;

    assign is_hdr    = (data_in == HEADER);
    assign pos_next  = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
    assign good_inc  = good_q + GW'(1);
    assign miss_inc  = miss_q + MW'(1);
    // acc_q holds the pending bits right-aligned with zeros above them.
    assign comb_bits = {acc_q, data_in};
    assign n_bits    = cnt_q + CW'(DIN_W);
    assign shift_amt = n_bits - CW'(OUT_W);
    assign rem_mask  = ~({CMB_W{1'b1}} << shift_amt);

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        good_d       = good_q;
        miss_d       = miss_q;
        unroll_d     = unroll_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        hdr_err_d    = 1'b0;

        case (state_q)
            HUNT: begin
                if (is_hdr) begin
                    state_d  = VERIFY;
                    pos_d    = PW'(1);
                    good_d   = '0;
                    unroll_d = 1'b0;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            VERIFY: begin
                pos_d = pos_next;
                if (pos_q == '0) begin
                    if (is_hdr) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            miss_d   = '0;
                            unroll_d = 1'b1;
                        end
                    end else begin
                        state_d = HUNT;
                        pos_d   = '0;
                    end
                end
            end
            LOCKED: begin
                pos_d = pos_next;
                if (pos_q == '0) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (is_hdr) begin
                        miss_d   = '0;
                        unroll_d = 1'b1;
                    end else begin
                        hdr_err_d = 1'b1;
                        unroll_d  = 1'b0;
                        miss_d    = miss_inc;
                        if (miss_inc == MW'(UNLOCK_COUNT)) begin
                            state_d = HUNT;
                            pos_d   = '0;
                            miss_d  = '0;
                            good_d  = '0;
                        end
                    end
                end else if (unroll_q) begin
                    if (n_bits >= CW'(OUT_W)) begin
                        data_out_d   = OUT_W'(comb_bits >> shift_amt);
                        data_valid_d = 1'b1;
                        acc_d        = OUT_W'(comb_bits & rem_mask);
                        cnt_d        = shift_amt;
                    end else begin
                        acc_d = comb_bits[OUT_W-1:0];
                        cnt_d = n_bits;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                pos_d   = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            pos_q        <= '0;
            good_q       <= '0;
            miss_q       <= '0;
            unroll_q     <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            good_q       <= good_d;
            miss_q       <= miss_d;
            unroll_q     <= unroll_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            locked_q     <= locked_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;
    assign hdr_err    = hdr_err_q;

endmodule

// File: rtl/elink_trig_unroller_multi.sv
// N_CH independent e-link trigger unrollers sharing one clock; top only slices the buses.
module elink_trig_unroller_multi
    import elink_trig_pkg::*;
#(
    parameter int               N_CH         = 4,
    parameter int               DIN_W        = 8,
    parameter int               OUT_W        = 10,
    parameter int               FRAME_BYTES  = 6,
    parameter logic [DIN_W-1:0] HEADER       = DIN_W'(HEADER_DEFAULT),
    parameter int               LOCK_COUNT   = 2,
    parameter int               UNLOCK_COUNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*DIN_W-1:0]   data_in,
    output logic [N_CH*OUT_W-1:0]   data_out,
    output logic [N_CH-1:0]         data_valid,
    output logic [N_CH-1:0]         locked,
    output logic [N_CH-1:0]         hdr_err
);

    localparam int WPF = words_per_frame(DIN_W, OUT_W, FRAME_BYTES);

    // A frame must carry whole words, and a byte may complete at most one word.
    generate
        if ((WPF * OUT_W != (FRAME_BYTES - 1) * DIN_W) || (DIN_W > OUT_W) ||
            (FRAME_BYTES < 2) || (LOCK_COUNT < 1) || (UNLOCK_COUNT < 1)) begin : g_bad_params
            $error("elink_trig_unroller_multi: illegal DIN_W/OUT_W/FRAME_BYTES/LOCK_COUNT/UNLOCK_COUNT");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            elink_trig_unroller_ch #(
                .DIN_W        (DIN_W),
                .OUT_W        (OUT_W),
                .FRAME_BYTES  (FRAME_BYTES),
                .HEADER       (HEADER),
                .LOCK_COUNT   (LOCK_COUNT),
                .UNLOCK_COUNT (UNLOCK_COUNT)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .data_in    (data_in[gi*DIN_W +: DIN_W]),
                .data_out   (data_out[gi*OUT_W +: OUT_W]),
                .data_valid (data_valid[gi]),
                .locked     (locked[gi]),
                .hdr_err    (hdr_err[gi])
            );
        end
    endgenerate

endmodule
